int_to_float: RTL
=================

Name: int_to_float

Overview:
- Sequential integer-to-float converter that sits directly upstream of the float arithmetic unit. It turns signed or unsigned integer operands into packed floats so they can be fed to that unit's operand inputs.
- It uses the same float format: sign, biased exponent, hidden-bit mantissa, with BITS, EXP_BITS and MANT_BITS parameters.
- Normalisation is iterative, one shift per clock. It uses the same start/ready handshake and output-enable convention as the arithmetic unit.

Parameters:
- BITS, 32, total float width
- EXP_BITS, 8, exponent field width
- MANT_BITS, BITS-EXP_BITS-1, stored mantissa width (hidden bit excluded)
- EXP_BIAS, 2^(EXP_BITS-1)-1, exponent bias
- INT_BITS, 32, integer input width; must satisfy INT_BITS-1+EXP_BIAS < 2^EXP_BITS-1

Ports:
- in_clk  input  1  clock
- in_rst  input  1  reset, synchronous, active-high
- in_enable  input  1  output enable; out_result is high-Z when 0
- in_start  input  1  start conversion; sampled only in Ready
- in_signed  input  1  1 means in_int is two's complement, 0 means unsigned
- in_int  input  INT_BITS  integer operand; must be held stable from the start edge through the Abs cycle
- out_result  output  BITS  packed float {sign, exp, mant}
- out_ready  output  1  high only in state Ready

Behaviour:
- One clock domain (in_clk). Reset is synchronous and active-high: on a rising edge with in_rst=1, state=Ready and the sign, exp, mag and result registers all clear to 0.
- After reset: out_ready=1 and out_result=0 (when enabled).
- Reset asserted mid-conversion aborts the conversion at the next edge, with the same values as above.
- State Ready:
  - out_ready=1.
  - If in_start=1, go to Abs at the next edge.
  - in_start is ignored in every other state.
- State Abs:
  - sign = in_signed & in_int[INT_BITS-1].
  - mag = sign ? -in_int : in_int, taken as INT_BITS unsigned, so the most negative value yields 2^(INT_BITS-1).
  - If the magnitude is 0: result = all zeros (sign also 0) and go to Ready.
  - Otherwise: exp = EXP_BIAS + INT_BITS - 1 and go to Norm.
- State Norm:
  - If mag[INT_BITS-1]=0: mag <<= 1, exp -= 1, stay in Norm.
  - Otherwise go to Pack.
  - Exactly one shift per cycle.
- State Pack:
  - mant = mag[INT_BITS-2 : 0], aligned to MANT_BITS.
    - If INT_BITS-1 > MANT_BITS, low bits are dropped (truncation toward zero).
    - If INT_BITS-1 < MANT_BITS, the field is zero-padded on the right.
  - result = {sign, exp, mant}; go to Ready.
- Latency:
  - Nonzero input: 4 + s cycles from the start-accepting edge to out_ready=1, where s = number of leading zeros of the magnitude.
  - Zero input: 2 cycles.
- out_result holds the last result until the next Pack or zero-result Abs completes. During a conversion it shows the previous result.
- out_result = (in_enable ? result : high-Z). out_ready does not depend on in_enable.
- Exponent never underflows: the minimum is EXP_BIAS for magnitude 1.

Optional Feature:
- Macro: INT_TO_FLOAT_ROUND_EN
- Defined:
  - Pack rounds to nearest, ties to even. Guard bit = the first dropped bit; sticky = OR of the remaining dropped bits.
  - Increment when guard & (sticky | mant[0]).
  - If the increment carries out of the mantissa field: mant=0 and exp+=1, within the same Pack cycle, so latency is unchanged.
  - Has no effect when INT_BITS-1 <= MANT_BITS.
- Undefined: truncation as described in Behaviour.

Test Plan:
- Reset pulse mid-conversion of in_int=1 -> next cycle out_ready=1, out_result=0x00000000; a subsequent start converts normally.
- in_signed=1, in_int=1 -> out_result=0x3F800000 after 35 cycles. in_int=0xFFFFFFFF (-1) -> 0xBF800000. in_int=0 -> 0x00000000 with out_ready back after 2 cycles.
- in_signed=1, in_int=0x80000000 -> 0xCF000000 after 4 cycles. in_signed=0, same input -> 0x4F000000.
- in_signed=0, in_int=16777219 (0x01000003):
  - macro off -> 0x4B800001.
  - macro on -> 0x4B800002 (tie rounds to even).
- in_signed=0, in_int=0xFFFFFFFF:
  - macro off -> 0x4F7FFFFF.
  - macro on -> 0x4F800000 (mantissa carry bumps the exponent).
- Handshake: in_start pulsed while busy is ignored and the result is unaffected; in_enable=0 -> out_result=Z while out_ready still toggles; in_start held high in Ready -> back-to-back conversions.

Source files
------------

// File: rtl/int_to_float_if.sv
// int_to_float_if: operand/result bundle between an integer source and the
// int_to_float converter. The master drives the operand, start and output
// enable; the slave (converter) drives the packed float and the ready flag.
interface int_to_float_if #(
  parameter int BITS     = 32,
  parameter int INT_BITS = 32
);
  logic                in_enable;
  logic                in_start;
  logic                in_signed;
  logic [INT_BITS-1:0] in_int;
  logic [BITS-1:0]     out_result;
  logic                out_ready;

  modport master (
    output in_enable,
    output in_start,
    output in_signed,
    output in_int,
    input  out_result,
    input  out_ready
  );

  modport slave (
    input  in_enable,
    input  in_start,
    input  in_signed,
    input  in_int,
    output out_result,
    output out_ready
  );
endinterface

// File: rtl/int_to_float.sv
// int_to_float: sequential signed/unsigned integer to packed float converter.
// Flow: Ready -> Abs (sign/magnitude) -> Norm (one left shift per clock until
// the magnitude MSB is set) -> Pack -> Ready. A zero magnitude returns from
// Abs directly. Define INT_TO_FLOAT_ROUND_EN to round the packed mantissa to
// nearest/ties-to-even instead of truncating it.
module int_to_float #(
  parameter int BITS      = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = BITS - EXP_BITS - 1,
  parameter int EXP_BIAS  = (1 << (EXP_BITS - 1)) - 1,
  parameter int INT_BITS  = 32
) (
  input  logic          in_clk,
  input  logic          in_rst,
  int_to_float_if.slave bus
);

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_ABS   = 2'd1,
    ST_NORM  = 2'd2,
    ST_PACK  = 2'd3
  } state_t;

  // Fraction bits available below the leading one, and how many of them do
  // not fit into the mantissa field.
  localparam int FRAC_BITS = INT_BITS - 1;
  localparam int DROP_BITS = (FRAC_BITS > MANT_BITS) ? (FRAC_BITS - MANT_BITS) : 0;
  localparam logic [EXP_BITS-1:0] EXP_START = EXP_BITS'(EXP_BIAS + INT_BITS - 1);

  state_t              state_reg, state_next;
  logic                sign_reg, sign_next;
  logic [EXP_BITS-1:0] exp_reg, exp_next;
  logic [INT_BITS-1:0] mag_reg, mag_next;
  logic [BITS-1:0]     result_reg, result_next;

  logic                abs_sign;
  logic [INT_BITS-1:0] abs_mag;
  logic [MANT_BITS-1:0] mant_trunc;
  logic [MANT_BITS-1:0] pack_mant;
  logic [EXP_BITS-1:0]  pack_exp;

  // Mantissa alignment: keep the top fraction bits, or pad on the right when
  // the integer has fewer fraction bits than the mantissa field.
  generate
    if (FRAC_BITS >= MANT_BITS) begin : g_trunc
      assign mant_trunc = mag_reg[INT_BITS-2 -: MANT_BITS];
    end else begin : g_pad
      assign mant_trunc = {mag_reg[INT_BITS-2:0], {(MANT_BITS - FRAC_BITS){1'b0}}};
    end
  endgenerate

`ifdef INT_TO_FLOAT_ROUND_EN
  logic                 guard_bit;
  logic                 sticky_bit;
  logic                 round_up;
  logic [MANT_BITS:0]   mant_inc;

  // Guard is the first dropped bit, sticky collects everything below it.
  generate
    if (DROP_BITS >= 2) begin : g_gs_wide
      assign guard_bit  = mag_reg[DROP_BITS-1];
      assign sticky_bit = |mag_reg[DROP_BITS-2:0];
    end else if (DROP_BITS == 1) begin : g_gs_one
      assign guard_bit  = mag_reg[0];
      assign sticky_bit = 1'b0;
    end else begin : g_gs_none
      assign guard_bit  = 1'b0;
      assign sticky_bit = 1'b0;
    end
  endgenerate

  assign round_up = guard_bit & (sticky_bit | mant_trunc[0]);
  assign mant_inc = {1'b0, mant_trunc} + 1'b1;

  // Rounded mantissa; a carry out of the field bumps the exponent.
  always_comb begin
    pack_mant = mant_trunc;
    pack_exp  = exp_reg;
    if (round_up) begin
      if (mant_inc[MANT_BITS]) begin
        pack_mant = '0;
        pack_exp  = exp_reg + 1'b1;
      end else begin
        pack_mant = mant_inc[MANT_BITS-1:0];
      end
    end
  end
`else
  // Truncation toward zero: the dropped low magnitude bits are simply ignored.
  generate
    if (DROP_BITS >= 1) begin : g_drop
      logic dropped_unused;
      assign dropped_unused = |mag_reg[DROP_BITS-1:0];
    end
  endgenerate

  // Truncated mantissa with the exponent as normalised.
  always_comb begin
    pack_mant = mant_trunc;
    pack_exp  = exp_reg;
  end
`endif

  // Sign and two's-complement magnitude of the operand (most negative value
  // wraps to 2^(INT_BITS-1), which is the correct unsigned magnitude).
  always_comb begin
    abs_sign = bus.in_signed & bus.in_int[INT_BITS-1];
    abs_mag  = abs_sign ? (~bus.in_int + 1'b1) : bus.in_int;
  end

  // Next-state and datapath update for the conversion sequence.
  always_comb begin
    state_next  = state_reg;
    sign_next   = sign_reg;
    exp_next    = exp_reg;
    mag_next    = mag_reg;
    result_next = result_reg;
    case (state_reg)
      ST_READY: begin
        if (bus.in_start) begin
          state_next = ST_ABS;
        end
      end
      ST_ABS: begin
        if (abs_mag == '0) begin
          sign_next   = 1'b0;
          mag_next    = '0;
          result_next = '0;
          state_next  = ST_READY;
        end else begin
          sign_next  = abs_sign;
          mag_next   = abs_mag;
          exp_next   = EXP_START;
          state_next = ST_NORM;
        end
      end
      ST_NORM: begin
        if (!mag_reg[INT_BITS-1]) begin
          mag_next = {mag_reg[INT_BITS-2:0], 1'b0};
          exp_next = exp_reg - 1'b1;
        end else begin
          state_next = ST_PACK;
        end
      end
      ST_PACK: begin
        result_next = {sign_reg, pack_exp, pack_mant};
        exp_next    = pack_exp;
        state_next  = ST_READY;
      end
      default: state_next = ST_READY;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_reg  <= ST_READY;
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      mag_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sign_reg   <= sign_next;
      exp_reg    <= exp_next;
      mag_reg    <= mag_next;
      result_reg <= result_next;
    end
  end

  assign bus.out_ready  = (state_reg == ST_READY);
  assign bus.out_result = bus.in_enable ? result_reg : 'z;

endmodule
